// File: rtl/protocore_pkg.sv
// Shared constants for the writeback scheduler: default widths and requester identities.
package protocore_pkg;

    localparam int AW_DEFAULT = 4;
    localparam int DW_DEFAULT = 8;
    localparam int CW_DEFAULT = 2;
    localparam int NREGS      = 2**AW_DEFAULT;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: captures on handshake, empties when granted the write port.
module wb_slot
    import protocore_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          grant_i,
    output logic          ready_o,
    output logic          full_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);

    logic          full_q, full_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    // A granted slot drains at the same edge it may refill.
    always_comb begin
        full_d  = full_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ready_o = ~full_q | grant_i;
        if (valid_i && ready_o) begin
            full_d = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end else if (grant_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the reg_file write port between ALU and LOAD writeback slots and tracks
// outstanding writes per register to raise read hazards for decode.
module regfile_wb_scheduler
    import protocore_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_addr,
    output logic          issue_ready,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic          hazard_a,
    output logic          hazard_b,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          we
);

    localparam int            NumRegs = 2**AW;
    localparam logic [CW-1:0] CntMax  = '1;

    logic          aluFull, ldFull;
    logic [AW-1:0] aluAddr, ldAddr;
    logic [DW-1:0] aluData, ldData;
    logic          aluGrant, ldGrant;
    logic          aluStay, ldStay;

    logic          ldOlder_q, ldOlder_d;
    req_e          prio_q, prio_d;
    logic [CW-1:0] cnt_q [NumRegs];
    logic [CW-1:0] cnt_d [NumRegs];
    logic          underflow_q, underflow_d;
    logic [NumRegs-1:0] incVec, decVec;

    wb_slot #(.AW(AW), .DW(DW)) u_aluSlot (
        .clk     (clk),
        .rst     (rst),
        .valid_i (alu_valid),
        .addr_i  (alu_addr),
        .data_i  (alu_data),
        .grant_i (aluGrant),
        .ready_o (alu_ready),
        .full_o  (aluFull),
        .addr_o  (aluAddr),
        .data_o  (aluData)
    );

    wb_slot #(.AW(AW), .DW(DW)) u_ldSlot (
        .clk     (clk),
        .rst     (rst),
        .valid_i (ld_valid),
        .addr_i  (ld_addr),
        .data_i  (ld_data),
        .grant_i (ldGrant),
        .ready_o (ld_ready),
        .full_o  (ldFull),
        .addr_o  (ldAddr),
        .data_o  (ldData)
    );

    // Same destination keeps fill order (WAW); different destinations share fairly.
    always_comb begin
        aluGrant = 1'b0;
        ldGrant  = 1'b0;
        prio_d   = prio_q;
        if (!rst) begin
            if (aluFull && ldFull) begin
                if (aluAddr == ldAddr) begin
                    ldGrant  = ldOlder_q;
                    aluGrant = ~ldOlder_q;
                end else begin
                    aluGrant = (prio_q == REQ_ALU);
                    ldGrant  = (prio_q == REQ_LD);
                    prio_d   = (prio_q == REQ_ALU) ? REQ_LD : REQ_ALU;
                end
            end else begin
                aluGrant = aluFull;
                ldGrant  = ldFull;
            end
        end
    end

    always_comb begin
        we = (aluFull | ldFull) & ~rst;
        wa = '0;
        wd = '0;
        if (ldGrant) begin
            wa = ldAddr;
            wd = ldData;
        end else if (aluGrant) begin
            wa = aluAddr;
            wd = aluData;
        end
    end

    // A slot that stays full is older than one filled at this edge; simultaneous fills favour ALU.
    always_comb begin
        aluStay = aluFull & ~aluGrant;
        ldStay  = ldFull & ~ldGrant;
        if (aluStay && ldStay) begin
            ldOlder_d = ldOlder_q;
        end else begin
            ldOlder_d = ldStay & ~aluStay;
        end
    end

    assign issue_ready = (cnt_q[issue_addr] != CntMax) | (we & (wa == issue_addr));
    assign hazard_a    = (cnt_q[ra] != '0);
    assign hazard_b    = (cnt_q[rb] != '0);

    always_comb begin
        incVec             = '0;
        decVec             = '0;
        incVec[issue_addr] = issue_valid & issue_ready;
        decVec[wa]         = we;
    end

    // A decrement with nothing outstanding is a protocol error: hold at zero and flag it.
    always_comb begin
        underflow_d = underflow_q;
        for (int r = 0; r < NumRegs; r++) begin
            cnt_d[r] = cnt_q[r];
            if (incVec[r] && !decVec[r]) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (decVec[r] && !incVec[r]) begin
                if (cnt_q[r] == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ldOlder_q   <= 1'b0;
            prio_q      <= REQ_ALU;
            underflow_q <= 1'b0;
            cnt_q       <= '{default: '0};
        end else begin
            ldOlder_q   <= ldOlder_d;
            prio_q      <= prio_d;
            underflow_q <= underflow_d;
            cnt_q       <= cnt_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !underflow_q);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomised and directed bench for regfile_wb_scheduler against a queue-based writeback model.
module tb_regfile_wb_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_valid, ld_valid, issue_valid;
    logic [3:0] alu_addr, ld_addr, issue_addr, ra, rb;
    logic [7:0] alu_data, ld_data;
    logic       alu_ready, ld_ready, issue_ready, hazard_a, hazard_b, we;
    logic [3:0] wa;
    logic [7:0] wd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         seq;
    } ent_t;

    ent_t        aluQ[$];
    ent_t        ldQ[$];
    int          seqCtr = 0;
    bit          rrLd   = 1'b0;
    int          cnt[16];
    int          tokens[16];
    logic [7:0]  regMem[16];
    logic [11:0] wrLog[$];
    int          cmpG;

    regfile_wb_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .ra          (ra),
        .rb          (rb),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .wa          (wa),
        .wd          (wd),
        .we          (we)
    );

    always #5 clk = ~clk;

    // Which requester owns the write port this cycle: -1 none, 0 ALU, 1 LOAD.
    function automatic int pick();
        if (rst) return -1;
        if (aluQ.size() > 0 && ldQ.size() > 0) begin
            if (aluQ[0].addr == ldQ[0].addr) return (aluQ[0].seq < ldQ[0].seq) ? 0 : 1;
            return rrLd ? 1 : 0;
        end
        if (aluQ.size() > 0) return 0;
        if (ldQ.size() > 0) return 1;
        return -1;
    endfunction

    function automatic logic [3:0] expWa(int g);
        if (g == 0) return aluQ[0].addr;
        if (g == 1) return ldQ[0].addr;
        return 4'd0;
    endfunction

    function automatic logic [7:0] expWd(int g);
        if (g == 0) return aluQ[0].data;
        if (g == 1) return ldQ[0].data;
        return 8'd0;
    endfunction

    function automatic bit expIssueReady(int g);
        return (cnt[issue_addr] < 3) || (g >= 0 && expWa(g) == issue_addr);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic modelStep();
        int         g;
        bit         aAcc, lAcc, iAcc;
        logic [3:0] a;
        if (rst) begin
            aluQ.delete();
            ldQ.delete();
            rrLd = 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt[i]    = 0;
                tokens[i] = 0;
            end
            return;
        end
        g    = pick();
        a    = expWa(g);
        iAcc = issue_valid && expIssueReady(g);
        aAcc = alu_valid && (aluQ.size() == 0 || g == 0);
        lAcc = ld_valid && (ldQ.size() == 0 || g == 1);
        if (g >= 0) begin
            if (aluQ.size() > 0 && ldQ.size() > 0 && aluQ[0].addr != ldQ[0].addr) rrLd = !rrLd;
            if (g == 0) void'(aluQ.pop_front());
            else        void'(ldQ.pop_front());
        end
        if (iAcc) begin
            cnt[issue_addr]++;
            tokens[issue_addr]++;
        end
        if (g >= 0 && cnt[a] > 0) cnt[a]--;
        if (aAcc) begin
            aluQ.push_back('{alu_addr, alu_data, seqCtr});
            seqCtr++;
            if (tokens[alu_addr] > 0) tokens[alu_addr]--;
        end
        if (lAcc) begin
            ldQ.push_back('{ld_addr, ld_data, seqCtr});
            seqCtr++;
            if (tokens[ld_addr] > 0) tokens[ld_addr]--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input bit r, input bit av, input logic [3:0] aa, input logic [7:0] ad,
                                 input bit lv, input logic [3:0] la, input logic [7:0] ldd,
                                 input bit iv, input logic [3:0] ia, input logic [3:0] rA, input logic [3:0] rB);
        rst         = r;
        alu_valid   = av;
        alu_addr    = aa;
        alu_data    = ad;
        ld_valid    = lv;
        ld_addr     = la;
        ld_data     = ldd;
        issue_valid = iv;
        issue_addr  = ia;
        ra          = rA;
        rb          = rB;
        #2;
    endtask

    task automatic idle(input logic [3:0] rA, input logic [3:0] rB);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, rA, rB);
    endtask

    // Every cycle: outputs against the model, and a reg_file stand-in that records committed writes.
    initial forever begin
        @(negedge clk);
        cmpG = pick();
        checkOutput("we", 32'(we), 32'(cmpG >= 0));
        checkOutput("wa", 32'(wa), 32'(expWa(cmpG)));
        checkOutput("wd", 32'(wd), 32'(expWd(cmpG)));
        checkOutput("alu_ready", 32'(alu_ready), 32'(aluQ.size() == 0 || cmpG == 0));
        checkOutput("ld_ready", 32'(ld_ready), 32'(ldQ.size() == 0 || cmpG == 1));
        checkOutput("issue_ready", 32'(issue_ready), 32'(expIssueReady(cmpG)));
        checkOutput("hazard_a", 32'(hazard_a), 32'(cnt[ra] != 0));
        checkOutput("hazard_b", 32'(hazard_b), 32'(cnt[rb] != 0));
        if (we === 1'b1) begin
            regMem[wa] = wd;
            wrLog.push_back({wa, wd});
        end
    end

    initial begin
        int          aluN, ldN, iss, cyc, logLen;
        bit          aAcc, lAcc, iAcc, r, av, lv;
        logic [3:0]  aa, la;
        logic [11:0] got, want;
        int          cand[$];

        // Reset with a request pending: nothing may be written.
        applyStimulus(1'b1, 1'b1, 4'd1, 8'h99, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        checkOutput("rst_we_c0", 32'(we), 32'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd1, 8'h99, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        checkOutput("rst_we_c1", 32'(we), 32'd0);
        tick();
        idle(4'd0, 4'd0);
        checkOutput("idle_alu_ready", 32'(alu_ready), 32'd1);
        checkOutput("idle_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("idle_issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("idle_hazards", 32'({hazard_a, hazard_b}), 32'd0);
        checkOutput("idle_wa_wd", 32'({wa, wd}), 32'd0);
        tick();

        // Single ALU write to r3.
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 4'd3, 4'd0);
        checkOutput("t2_issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("t2_haz_before", 32'(hazard_a), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'd3, 8'hAA, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 4'd3, 4'd0);
        checkOutput("t2_haz_after_issue", 32'(hazard_a), 32'd1);
        tick();
        idle(4'd3, 4'd0);
        checkOutput("t2_write", 32'({we, wa, wd}), 32'({1'b1, 4'd3, 8'hAA}));
        tick();
        idle(4'd3, 4'd0);
        checkOutput("t2_haz_cleared", 32'(hazard_a), 32'd0);
        checkOutput("t2_r3", 32'(regMem[3]), 32'hAA);
        tick();

        // Both requesters, different destinations, four transfers each.
        wrLog.delete();
        aluN = 0; ldN = 0; iss = 0; cyc = 0;
        while ((aluN < 4 || ldN < 4 || wrLog.size() < 8) && cyc < 30) begin
            applyStimulus(1'b0, aluN < 4, 4'd1, 8'(8'h10 + aluN), ldN < 4, 4'd2, 8'(8'h20 + ldN),
                          iss < 8, (iss % 2 == 0) ? 4'd1 : 4'd2, 4'd1, 4'd2);
            aAcc = alu_valid && alu_ready;
            lAcc = ld_valid && ld_ready;
            iAcc = issue_valid && issue_ready;
            tick();
            if (aAcc) aluN++;
            if (lAcc) ldN++;
            if (iAcc) iss++;
            cyc++;
        end
        checkOutput("rr_write_count", 32'(wrLog.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            want = {(k % 2 == 0) ? 4'd1 : 4'd2, 8'(((k % 2 == 0) ? 8'h10 : 8'h20) + k / 2)};
            got  = (k < wrLog.size()) ? wrLog[k] : 12'hFFF;
            checkOutput($sformatf("rr_write_%0d", k), 32'(got), 32'(want));
        end

        // WAW on r5: LOAD first, then ALU one edge later.
        idle(4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 4'd5, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 4'd5, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 8'h55, 1'b0, 4'd0, 4'd5, 4'd0);
        checkOutput("waw_haz", 32'(hazard_a), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 4'd5, 8'h66, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 4'd5, 4'd0);
        checkOutput("waw_first", 32'({we, wa, wd}), 32'({1'b1, 4'd5, 8'h55}));
        tick();
        idle(4'd5, 4'd0);
        checkOutput("waw_second", 32'({we, wa, wd}), 32'({1'b1, 4'd5, 8'h66}));
        checkOutput("waw_haz_mid", 32'(hazard_a), 32'd1);
        tick();
        idle(4'd5, 4'd0);
        checkOutput("waw_haz_done", 32'(hazard_a), 32'd0);
        checkOutput("waw_r5", 32'(regMem[5]), 32'h66);
        tick();

        // Saturate r7, then accept a fourth issue only alongside a write to r7.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 4'd7, 4'd0);
            checkOutput($sformatf("sat_issue_%0d", k), 32'(issue_ready), 32'd1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 4'd7, 4'd0);
        checkOutput("sat_block", 32'(issue_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'd7, 8'h77, 1'b0, 4'd0, 8'd0, 1'b0, 4'd7, 4'd7, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 4'd7, 4'd0);
        checkOutput("sat_bypass_we", 32'({we, wa}), 32'({1'b1, 4'd7}));
        checkOutput("sat_bypass_ready", 32'(issue_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 4'd7, 4'd0);
        checkOutput("sat_hold", 32'(issue_ready), 32'd0);
        tick();

        // Reset while both slots hold writes.
        applyStimulus(1'b0, 1'b1, 4'd7, 8'hA1, 1'b1, 4'd7, 8'hB2, 1'b0, 4'd0, 4'd7, 4'd7);
        tick();
        logLen = wrLog.size();
        applyStimulus(1'b1, 1'b1, 4'd7, 8'hC3, 1'b1, 4'd7, 8'hC4, 1'b0, 4'd0, 4'd7, 4'd7);
        checkOutput("rst_mid_we", 32'({we, wa, wd}), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd7, 4'd7, 4'd7);
        checkOutput("rst_mid_readies", 32'({alu_ready, ld_ready, issue_ready}), 32'h7);
        checkOutput("rst_mid_hazards", 32'({hazard_a, hazard_b}), 32'd0);
        checkOutput("rst_mid_we_after", 32'(we), 32'd0);
        tick();
        checkOutput("rst_mid_no_write", 32'(wrLog.size()), 32'(logLen));
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd0, 4'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'd0, 8'h01, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        idle(4'd0, 4'd0);
        checkOutput("post_rst_write", 32'({we, wa, wd}), 32'({1'b1, 4'd0, 8'h01}));
        tick();
        idle(4'd0, 4'd0);
        checkOutput("post_rst_r0", 32'(regMem[0]), 32'h01);
        tick();

        // Random traffic; writes only target registers with a reservation still unclaimed.
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            cand.delete();
            for (int i = 0; i < 16; i++) if (tokens[i] > 0) cand.push_back(i);
            av = (cand.size() > 0) && ($urandom_range(0, 9) < 6);
            aa = av ? 4'(cand[$urandom_range(0, cand.size() - 1)]) : 4'($urandom_range(0, 15));
            cand.delete();
            for (int i = 0; i < 16; i++)
                if (tokens[i] - ((av && aa == 4'(i)) ? 1 : 0) > 0) cand.push_back(i);
            lv = (cand.size() > 0) && ($urandom_range(0, 9) < 6);
            la = lv ? 4'(cand[$urandom_range(0, cand.size() - 1)]) : 4'($urandom_range(0, 15));
            applyStimulus(r, av, aa, 8'($urandom), lv, la, 8'($urandom),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            tick();
        end
        idle(4'd0, 4'd0);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
